instr_fetch: RTL and testbench

- Instruction fetch stage with IF/ID pipeline register. Feeds the decode stage: instruction word to the immediate generator and decoder, plus PC and PC+4.
- Owns the PC register and a single-outstanding-request handshake to instruction memory (variable latency, including same-cycle response).
- Supports decode stall, and branch/jump redirect with flush of in-flight and buffered fetches.

---
 rtl/instr_fetch.sv | 135 +++++++++++++
 tb/tb_instr_fetch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, single-outstanding imem handshake,
// skid buffer for decode stall, redirect with drain of stale requests, IF/ID register.
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic        valid_o
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drain_addr_q, drain_addr_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic        valid_q, valid_d;

   always_comb begin
      // NOTE: every _d defaults to its _q so no path through the case infers a latch.
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      buf_instr_d  = buf_instr_q;
      buf_pc_d     = buf_pc_q;
      instr_d      = instr_q;
      id_pc_d      = id_pc_q;
      valid_d      = valid_q;

      if (redirect_valid_i) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
         pc_d    = {redirect_pc_i[31:2], 2'b00};
         unique case (state_q)
            S_REQ: begin
               if (!imem_ready_i) begin
                  state_d      = S_DRAIN;
                  drain_addr_d = pc_q;
               end
            end
            S_HOLD:  state_d = S_REQ;
            S_DRAIN: state_d = imem_ready_i ? S_REQ : S_DRAIN;
            default: state_d = S_REQ;
         endcase
      end else begin
         unique case (state_q)
            S_REQ: begin
               if (imem_ready_i) begin
                  pc_d = pc_q + 32'd4;
                  if (stall_i) begin
                     buf_instr_d = imem_rdata_i;
                     buf_pc_d    = pc_q;
                     state_d     = S_HOLD;
                  end else begin
                     instr_d = imem_rdata_i;
                     id_pc_d = pc_q;
                     valid_d = 1'b1;
                  end
               end else if (!stall_i) begin
                  valid_d = 1'b0;
                  instr_d = NOP_INSTR;
               end
            end
            S_HOLD: begin
               if (!stall_i) begin
                  instr_d = buf_instr_q;
                  id_pc_d = buf_pc_q;
                  valid_d = 1'b1;
                  state_d = S_REQ;
               end
            end
            S_DRAIN: begin
               // The response belongs to the pre-redirect stream and is dropped.
               if (imem_ready_i) state_d = S_REQ;
               if (!stall_i) begin
                  valid_d = 1'b0;
                  instr_d = NOP_INSTR;
               end
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous and wins over any response arriving the same edge.
      if (rst) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         buf_instr_q  <= '0;
         buf_pc_q     <= '0;
         instr_q      <= NOP_INSTR;
         id_pc_q      <= RESET_PC;
         valid_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         buf_instr_q  <= buf_instr_d;
         buf_pc_q     <= buf_pc_d;
         instr_q      <= instr_d;
         id_pc_q      <= id_pc_d;
         valid_q      <= valid_d;
      end
   end

   // Request and address depend only on state so they stay stable while waiting.
   assign imem_req_o  = (state_q != S_HOLD);
   assign imem_addr_o = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
   assign instr_o     = instr_q;
   assign pc_o        = id_pc_q;
   assign pc_plus4_o  = id_pc_q + 32'd4;
   assign valid_o     = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios then randomized
// stall/redirect/reset/latency traffic against a transaction-level reference model.
module tb_instr_fetch;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        redirect_valid_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic [31:0] pc_plus4_o;
   logic        valid_o;

   instr_fetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .clk              (clk),
      .rst              (rst),
      .stall_i          (stall_i),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .imem_req_o       (imem_req_o),
      .imem_addr_o      (imem_addr_o),
      .imem_ready_i     (imem_ready_i),
      .imem_rdata_i     (imem_rdata_i),
      .instr_o          (instr_o),
      .pc_o             (pc_o),
      .pc_plus4_o       (pc_plus4_o),
      .valid_o          (valid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: program counter, pending stale fetch, buffered instruction, IF/ID view.
   logic [31:0] m_pc, m_stale_addr, m_buf_instr, m_buf_pc, m_instr, m_idpc;
   bit          m_stale, m_have_buf, m_valid;

   // Memory responder used in random mode.
   bit mem_busy = 1'b0;
   int mem_cnt  = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A00_0013;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_update(input bit r, input bit st, input bit rv,
                               input logic [31:0] rp, input bit rd);
      if (r) begin
         m_pc = RESET_PC; m_stale = 0; m_have_buf = 0;
         m_valid = 0; m_instr = NOP_INSTR; m_idpc = RESET_PC;
      end else if (rv) begin
         m_valid = 0; m_instr = NOP_INSTR;
         if (m_stale) m_stale = !rd;
         else if (!m_have_buf) begin
            m_stale      = !rd;
            m_stale_addr = m_pc;
         end
         m_have_buf = 0;
         m_pc       = rp & ~32'h3;
      end else if (m_have_buf) begin
         if (!st) begin
            m_valid = 1; m_instr = m_buf_instr; m_idpc = m_buf_pc; m_have_buf = 0;
         end
      end else if (m_stale) begin
         if (rd) m_stale = 0;
         if (!st) begin m_valid = 0; m_instr = NOP_INSTR; end
      end else begin
         if (rd) begin
            if (st) begin
               m_have_buf = 1; m_buf_instr = mem_word(m_pc); m_buf_pc = m_pc;
            end else begin
               m_valid = 1; m_instr = mem_word(m_pc); m_idpc = m_pc;
            end
            m_pc = m_pc + 32'd4;
         end else if (!st) begin
            m_valid = 0; m_instr = NOP_INSTR;
         end
      end
   endtask

   task automatic check_outputs();
      check("valid", {31'b0, valid_o}, {31'b0, m_valid});
      check("instr", instr_o, m_instr);
      check("pc", pc_o, m_idpc);
      check("pc_plus4", pc_plus4_o, m_idpc + 32'd4);
      check("req", {31'b0, imem_req_o}, {31'b0, !m_have_buf});
      if (!m_have_buf) check("addr", imem_addr_o, m_stale ? m_stale_addr : m_pc);
   endtask

   // One clock: drive at negedge, let the DUT take the edge, then compare. rdy<0 = random memory.
   task automatic step(input bit r, input bit st, input bit rv,
                       input logic [31:0] rp, input int rdy);
      bit rd;
      @(negedge clk);
      if (rdy < 0) begin
         if (!mem_busy && imem_req_o) begin
            mem_busy = 1;
            mem_cnt  = $urandom_range(0, 2);
         end
         rd = mem_busy && (mem_cnt == 0);
      end else begin
         rd       = (rdy != 0);
         mem_busy = 0;
      end
      rst              = r;
      stall_i          = st;
      redirect_valid_i = rv;
      redirect_pc_i    = rp;
      imem_ready_i     = rd;
      imem_rdata_i     = rd ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      if (mem_busy) begin
         if (rd || r) mem_busy = 0;
         else mem_cnt--;
      end
      model_update(r, st, rv, rp, rd);
      check_outputs();
   endtask

   initial begin
      bit r, st, rv;
      logic [31:0] rp;
      rst = 1; stall_i = 0; redirect_valid_i = 0; redirect_pc_i = '0;
      imem_ready_i = 0; imem_rdata_i = '0;

      // Reset with a response arriving in the reset cycle: it must be dropped.
      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      check("rst_valid", {31'b0, valid_o}, 32'd0);
      check("rst_instr", instr_o, NOP_INSTR);
      check("rst_pc4", pc_plus4_o, RESET_PC + 32'd4);

      // Zero-wait streaming.
      step(0, 0, 0, 0, 1);
      check("stream_first_valid", {31'b0, valid_o}, 32'd1);
      check("stream_pc0", pc_o, 32'h0);
      step(0, 0, 0, 0, 1);
      check("stream_pc1", pc_o, 32'h4);
      step(0, 0, 0, 0, 1);
      check("stream_pc2", pc_o, 32'h8);
      check("stream_instr2", instr_o, mem_word(32'h8));

      // Two-cycle latency from a fresh reset.
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("lat_addr_hold", imem_addr_o, 32'h0);
      step(0, 0, 0, 0, 1);
      check("lat_pc0", pc_o, 32'h0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      check("lat_pc1", pc_o, 32'h4);

      // Stall for three cycles while the 0x8 response arrives.
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 1);
      check("hold_req", {31'b0, imem_req_o}, 32'd0);
      step(0, 1, 0, 0, 0);
      check("hold_pc", pc_o, 32'h4);
      step(0, 0, 0, 0, 0);
      check("hold_release_pc", pc_o, 32'h8);
      step(0, 0, 0, 0, 1);
      check("after_hold_pc", pc_o, 32'hC);

      // Redirect while the 0x10 fetch is outstanding.
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 32'h102, 0);
      check("drain_addr", imem_addr_o, 32'h10);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      check("drain_bubble", {31'b0, valid_o}, 32'd0);
      check("redir_addr", imem_addr_o, 32'h100);
      step(0, 0, 0, 0, 1);
      check("redir_first_pc", pc_o, 32'h100);

      // Redirect while stalled in HOLD: buffered 0x104 must never emerge.
      step(0, 1, 0, 0, 1);
      step(0, 1, 1, 32'h200, 0);
      check("hold_redir_valid", {31'b0, valid_o}, 32'd0);
      step(0, 0, 0, 0, 1);
      check("hold_redir_pc", pc_o, 32'h200);

      // Wrap at the top of the address space.
      step(0, 0, 1, 32'hFFFF_FFFE, 1);
      step(0, 0, 0, 0, 1);
      check("wrap_pc", pc_o, 32'hFFFF_FFFC);
      check("wrap_pc4", pc_plus4_o, 32'h0);
      step(0, 0, 0, 0, 1);
      check("wrap_next_pc", pc_o, 32'h0);

      // Reset during DRAIN with a late response.
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 32'h40, 0);
      step(1, 0, 0, 0, 1);
      check("rst_drain_addr", imem_addr_o, RESET_PC);
      check("rst_drain_valid", {31'b0, valid_o}, 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 199) == 0);
         st = ($urandom_range(0, 3) == 0);
         rv = ($urandom_range(0, 11) == 0);
         rp = $urandom;
         step(r, st, rv, rp, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
